// File: rtl/toycpu_pkg.sv
// Shared toycpu definitions: program-loader state encoding,
// default frame header byte and a state classification helper.
package toycpu_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } ld_state_e;

    localparam logic [7:0] LD_HDR_DEFAULT = 8'hA5;

    // True for the states that make up an in-progress frame.
    function automatic logic ld_in_frame(input ld_state_e s);
        return (s == LD_COUNT)   || (s == LD_DATA_HI) ||
               (s == LD_DATA_LO) || (s == LD_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader_tmo.sv
// Inter-byte idle watchdog for the program loader: counts clk cycles
// since the last accepted byte while a frame is in progress.
module prog_loader_tmo #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart on every byte or outside a frame; saturate at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || kick) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The edge that completes TIMEOUT idle cycles is the expiry edge.
    assign expired = run && !kick && (cnt_q == CW'(TIMEOUT - 1));

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses HDR, N, 2N data bytes and an XOR
// checksum, writes 16-bit words to instruction memory, holds the CPU in reset.
module prog_loader
    import toycpu_pkg::*;
#(
    parameter int         DEPTH   = 128,
    parameter int         TIMEOUT = 100000,
    parameter logic [7:0] HDR     = LD_HDR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     imem_we,
    output logic [$clog2(DEPTH)-1:0] imem_addr,
    output logic [15:0]              imem_wdata,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);

    ld_state_e       state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      chk_q, chk_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            tmo_expired;
    logic            last_word;

    prog_loader_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .run     (busy_q),
        .kick    (rx_valid),
        .expired (tmo_expired)
    );

    assign last_word = (addr_q == AW'(n_q - 8'd1));

    // Next-state and output computation for the frame parser.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        hi_d      = hi_q;
        chk_d     = chk_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        cpu_rst_d = cpu_rst_q;
        err_d     = err_q;

        // Advance the address the cycle after a write, except after the
        // final word so the address never leaves the memory range.
        if (we_q && state_q != LD_CHECK) begin
            addr_d = addr_q + AW'(1);
        end

        unique case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (rx_valid && rx_data == HDR) begin
                    state_d   = LD_COUNT;
                    cpu_rst_d = 1'b1;
                    err_d     = 1'b0;
                    chk_d     = 8'h00;
                end
            end
            LD_COUNT: begin
                if (rx_valid) begin
                    if (rx_data != 8'h00 && int'(rx_data) <= DEPTH) begin
                        n_d     = rx_data;
                        addr_d  = '0;
                        state_d = LD_DATA_HI;
                    end else begin
                        state_d = LD_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            LD_DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = LD_DATA_LO;
                end
            end
            LD_DATA_LO: begin
                if (rx_valid) begin
                    chk_d   = chk_q ^ rx_data;
                    wdata_d = {hi_q, rx_data};
                    we_d    = 1'b1;
                    state_d = last_word ? LD_CHECK : LD_DATA_HI;
                end
            end
            LD_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d   = LD_DONE;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = LD_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase

        if (tmo_expired) begin
            state_d = LD_ERROR;
            err_d   = 1'b1;
        end

        busy_d = ld_in_frame(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LD_IDLE;
            n_q       <= 8'h00;
            hi_q      <= 8'h00;
            chk_q     <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            hi_q      <= hi_d;
            chk_q     <= chk_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are built from the byte-level
// frame rules, expected writes queued, a monitor checks every write.
module tb_prog_loader;

    localparam int DEPTH   = 128;
    localparam int TIMEOUT = 50;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [22:0] exp_q[$];
    logic [15:0] exp_mem [DEPTH];
    logic [15:0] mem     [DEPTH];
    logic        we_prev = 1'b0;
    logic        model_err = 1'b0;
    logic        model_crst = 1'b0;

    prog_loader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .HDR     (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("we_pulse_width", 32'(we_prev), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h/%0h expected none",
                         imem_addr, imem_wdata);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e[22:16]));
                chk("wr_data", 32'(imem_wdata), 32'(e[15:0]));
            end
            mem[imem_addr] = imem_wdata;
        end
        we_prev = imem_we;
    end

    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            drive(q[i]);
        end
    endtask

    task automatic expect_write(input int a, input logic [15:0] w);
        exp_q.push_back({7'(a), w});
        exp_mem[a] = w;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_err"}, 32'(err), 32'(model_err));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(model_crst));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Reference model of one frame, from the frame rules alone.
    task automatic rand_frame(input int n, input bit bad, input int maxgap);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [15:0] w;
        x = 8'h00;
        q.push_back(8'hA5);
        q.push_back(8'(n));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 7) == 0) w[15:8] = 8'hA5;
                if ($urandom_range(0, 7) == 0) w[7:0] = 8'hA5;
                q.push_back(w[15:8]);
                q.push_back(w[7:0]);
                x = x ^ w[15:8] ^ w[7:0];
                expect_write(i, w);
            end
            if (bad) x = x ^ 8'($urandom_range(1, 255));
            q.push_back(x);
            model_err = bad;
        end else begin
            model_err = 1'b1;
        end
        model_crst = model_err;
        send(q, maxgap);
        check_status("frame");
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = 16'h0;
            mem[i]     = 16'h0;
        end
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(2);
        chk("rst_cpu_rst", 32'(cpu_rst), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", 32'(imem_wdata), 0);
        rst = 1'b0;
        idle(1);

        // Two-word good frame, back to back.
        expect_write(0, 16'h1234);
        expect_write(1, 16'hABCD);
        q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        model_err = 0; model_crst = 0;
        send(q, 0);
        check_status("good2");

        // Bytes in DONE other than HDR are ignored.
        drive(8'h00);
        drive(8'hFF);
        check_status("done_junk");
        drive(8'hA5);
        chk("new_hdr_cpu_rst", 32'(cpu_rst), 1);
        chk("new_hdr_busy", 32'(busy), 1);
        chk("new_hdr_err", 32'(err), 0);
        expect_write(0, 16'h5566);
        q = '{8'h01, 8'h55, 8'h66, 8'h33};
        send(q, 0);
        check_status("good1");

        // Bad checksum after one written word.
        expect_write(0, 16'h1234);
        q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
        model_err = 1; model_crst = 1;
        send(q, 0);
        check_status("bad_chk");

        // Illegal word counts.
        q = '{8'hA5, 8'h00};
        send(q, 0);
        check_status("n_zero");
        q = '{8'hA5, 8'h81};
        send(q, 0);
        check_status("n_big");

        // Inter-byte timeout.
        q = '{8'hA5, 8'h01, 8'h12};
        send(q, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("tmo_before_err", 32'(err), 0);
        chk("tmo_before_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        chk("tmo_at_err", 32'(err), 1);
        chk("tmo_at_busy", 32'(busy), 0);
        chk("tmo_at_cpu_rst", 32'(cpu_rst), 1);
        @(negedge clk);

        // Reset mid-frame after one word.
        expect_write(0, 16'h1234);
        q = '{8'hA5, 8'h02, 8'h12, 8'h34};
        send(q, 0);
        idle(1);
        rst = 1'b1;
        #1;
        chk("midrst_cpu_rst", 32'(cpu_rst), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_addr", 32'(imem_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("midrst_mem0", 32'(mem[0]), 32'h1234);
        model_err = 0; model_crst = 0;
        rand_frame(3, 1'b0, 2);

        // Randomised frames, gaps, junk, full-depth frame.
        rand_frame(DEPTH, 1'b0, 1);
        for (int f = 0; f < 24; f++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(129, 255);
            else if (r == 1) n = DEPTH;
            else             n = $urandom_range(1, 16);
            rand_frame(n, $urandom_range(0, 3) == 0, 3);
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                drive(j);
            end
            check_status("after_junk");
        end

        idle(5);
        chk("queue_empty", 32'(exp_q.size()), 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("mem_final", {i[15:0], mem[i]}, {i[15:0], exp_mem[i]});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
